peak_record_serializer: RTL and testbench

PEAK_RECORD_SERIALIZER -- requirements
Module: peak_record_serializer

---
 rtl/peak_record_pkg.sv | 22 ++
 rtl/peak_record_fifo.sv | 61 ++++++
 rtl/peak_record_serializer.sv | 162 ++++++++++++++++
 tb/tb_peak_record_serializer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peak_record_pkg.sv
// Shared definitions for the peak-record serializer: FSM encoding, beat
// ratio of the default configuration and the record header magic word.
package peak_record_pkg;

  // Output beats per record for the default 512 -> 64 configuration.
  localparam int BEATS = 8;

  // Header word carried in the least-significant 32 bits of every record.
  localparam logic [31:0] PK_MAGIC = 32'h504B504B;

  // Serializer FSM encoding.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_t;

  // Bit width needed to index v items, never less than one bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/peak_record_fifo.sv
// Synchronous first-word-fall-through record buffer. The head entry is
// presented on rd_data whenever empty is low; rd_en consumes it.
// Full/empty come from the registered level, so a write is judged against
// the occupancy at the start of the cycle, before any same-cycle pop.
module peak_record_fifo
  import peak_record_pkg::*;
#(
  parameter int WIDTH = 512,
  parameter int DEPTH = 4
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = clog2_min1(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             do_wr;
  logic             do_rd;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem[rd_ptr_q];
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;

  // Pointer and occupancy bookkeeping; a simultaneous write and pop cancel.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage array; contents need no reset because level gates every read.
  always_ff @(posedge aclk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/peak_record_serializer.sv
// Peak-record serializer: buffers wide single-beat records and emits each
// one as IN_DATA_WIDTH/OUT_DATA_WIDTH narrow beats, least-significant word
// first, with tlast on the final beat.
//
// Handshake semantics (both streams): a beat transfers on a rising edge
// where tvalid and tready are both high. Once m_axis_tvalid is asserted the
// beat (tdata/tlast) is held unchanged until it transfers; tvalid never
// waits on tready. On the input side, s_axis_tready is either constant 1
// (drop mode, excess records are counted and discarded) or !full taken from
// registered occupancy only, so it never depends on m_axis_tready.
module peak_record_serializer
  import peak_record_pkg::*;
#(
  parameter int IN_DATA_WIDTH  = 512,
  parameter int OUT_DATA_WIDTH = 64,
  parameter int FIFO_DEPTH     = 4,
  parameter int DROP_WHEN_FULL = 1
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [IN_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic [OUT_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic [OUT_DATA_WIDTH/8-1:0]   m_axis_tkeep,
  input  logic                          m_axis_tready,
  output logic [31:0]                   rec_count,
  output logic [31:0]                   drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output ser_state_t                    dbg_state
);

  localparam int NUM_BEATS = IN_DATA_WIDTH / OUT_DATA_WIDTH;
  localparam int BEAT_W    = clog2_min1(NUM_BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  ser_state_t                state_q, state_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [IN_DATA_WIDTH-1:0]  sr_q;
  logic                      load, shift, clear, rec_done;
  logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [IN_DATA_WIDTH-1:0]  fifo_rd_data;
  logic                      drop_evt;
  logic                      ready_en_q;
  logic [31:0]               rec_count_q, drop_count_q;
  logic                      unused_tlast;

  // Every accepted beat is a whole record; the input tlast carries nothing.
  assign unused_tlast = s_axis_tlast;

  assign s_axis_tready = (DROP_WHEN_FULL != 0) ? 1'b1 : (ready_en_q & ~fifo_full);
  assign fifo_push     = s_axis_tvalid & s_axis_tready & ~fifo_full;
  assign drop_evt      = (DROP_WHEN_FULL != 0) && s_axis_tvalid && fifo_full;

  assign m_axis_tvalid = (state_q == ST_SEND);
  assign m_axis_tlast  = (state_q == ST_SEND) && (beat_q == LAST_BEAT);
  assign m_axis_tdata  = sr_q[OUT_DATA_WIDTH-1:0];
  assign m_axis_tkeep  = '1;
  assign rec_count     = rec_count_q;
  assign drop_count    = drop_count_q;
  assign dbg_state     = state_q;

  peak_record_fifo #(
    .WIDTH (IN_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .wr_en   (fifo_push),
    .wr_data (s_axis_tdata),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Serializer next-state: load a record, walk its beats, chain records.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    fifo_pop = 1'b0;
    load     = 1'b0;
    shift    = 1'b0;
    clear    = 1'b0;
    rec_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          load     = 1'b1;
          fifo_pop = 1'b1;
          beat_d   = '0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (m_axis_tready) begin
          if (beat_q != LAST_BEAT) begin
            beat_d = beat_q + BEAT_W'(1);
            shift  = 1'b1;
          end else begin
            rec_done = 1'b1;
            beat_d   = '0;
            if (!fifo_empty) begin
              load     = 1'b1;
              fifo_pop = 1'b1;
            end else begin
              clear   = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and beat index registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Shift register: the low word is always the beat on the wire.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= fifo_rd_data;
    end else if (shift) begin
      sr_q <= sr_q >> OUT_DATA_WIDTH;
    end else if (clear) begin
      sr_q <= '0;
    end
  end

  // Input-ready enable: low through reset, high from the first cycle after.
  always_ff @(posedge aclk) begin
    if (!aresetn) ready_en_q <= 1'b0;
    else          ready_en_q <= 1'b1;
  end

  // Saturating record and drop counters.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rec_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      if (rec_done && rec_count_q != 32'hFFFF_FFFF)  rec_count_q  <= rec_count_q + 32'd1;
      if (drop_evt && drop_count_q != 32'hFFFF_FFFF) drop_count_q <= drop_count_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_peak_record_serializer.sv
// Directed bench for peak_record_serializer. Instance a runs the drop-when-
// full configuration, instance b the backpressure configuration; both share
// clock and reset. Outputs are sampled 1 time unit after the rising edge and
// beats are scored on the falling edge.
module tb_peak_record_serializer;
  import peak_record_pkg::*;

  localparam int IW = 512;
  localparam int OW = 64;
  localparam int KW = OW / 8;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  // ---------------- instance a (drop mode) ----------------
  logic [IW-1:0] a_s_tdata;
  logic          a_s_tvalid, a_s_tlast, a_s_tready;
  logic [OW-1:0] a_m_tdata;
  logic          a_m_tvalid, a_m_tlast, a_m_tready;
  logic [KW-1:0] a_m_tkeep;
  logic [31:0]   a_rec_count, a_drop_count;
  logic [2:0]    a_fifo_level;
  ser_state_t    a_dbg_state;

  peak_record_serializer #(
    .IN_DATA_WIDTH(IW), .OUT_DATA_WIDTH(OW), .FIFO_DEPTH(4), .DROP_WHEN_FULL(1)
  ) dut_a (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(a_s_tdata), .s_axis_tvalid(a_s_tvalid), .s_axis_tlast(a_s_tlast),
    .s_axis_tready(a_s_tready),
    .m_axis_tdata(a_m_tdata), .m_axis_tvalid(a_m_tvalid), .m_axis_tlast(a_m_tlast),
    .m_axis_tkeep(a_m_tkeep), .m_axis_tready(a_m_tready),
    .rec_count(a_rec_count), .drop_count(a_drop_count), .fifo_level(a_fifo_level),
    .dbg_state(a_dbg_state)
  );

  // ---------------- instance b (backpressure mode) ----------------
  logic [IW-1:0] b_s_tdata;
  logic          b_s_tvalid, b_s_tlast, b_s_tready;
  logic [OW-1:0] b_m_tdata;
  logic          b_m_tvalid, b_m_tlast, b_m_tready;
  logic [KW-1:0] b_m_tkeep;
  logic [31:0]   b_rec_count, b_drop_count;
  logic [2:0]    b_fifo_level;
  ser_state_t    b_dbg_state;

  peak_record_serializer #(
    .IN_DATA_WIDTH(IW), .OUT_DATA_WIDTH(OW), .FIFO_DEPTH(4), .DROP_WHEN_FULL(0)
  ) dut_b (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(b_s_tdata), .s_axis_tvalid(b_s_tvalid), .s_axis_tlast(b_s_tlast),
    .s_axis_tready(b_s_tready),
    .m_axis_tdata(b_m_tdata), .m_axis_tvalid(b_m_tvalid), .m_axis_tlast(b_m_tlast),
    .m_axis_tkeep(b_m_tkeep), .m_axis_tready(b_m_tready),
    .rec_count(b_rec_count), .drop_count(b_drop_count), .fifo_level(b_fifo_level),
    .dbg_state(b_dbg_state)
  );

  // ---------------- checking ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- record builders ----------------
  // Word 0 carries the magic header; each word is tagged {record, word index}.
  function automatic logic [IW-1:0] make_rec(input int tag);
    logic [IW-1:0] r;
    for (int w = 0; w < BEATS; w++) begin
      if (w == 0) r[64*w +: 64] = {8'(tag), 8'(w), 16'hBEEF, PK_MAGIC};
      else        r[64*w +: 64] = {8'(tag), 8'(w), 16'hBEEF, 16'hBEEF, 8'(tag), 8'(w)};
    end
    return r;
  endfunction

  function automatic logic [IW-1:0] inc_rec();
    logic [IW-1:0] r;
    for (int i = 0; i < IW / 8; i++) r[8*i +: 8] = 8'(i);
    return r;
  endfunction

  // ---------------- scoreboards ----------------
  logic [64:0] exp_a_q[$];
  logic [64:0] exp_b_q[$];

  task automatic push_exp_a(input logic [IW-1:0] r);
    for (int w = 0; w < BEATS; w++) exp_a_q.push_back({(w == BEATS - 1), r[64*w +: 64]});
  endtask

  task automatic push_exp_b(input logic [IW-1:0] r);
    for (int w = 0; w < BEATS; w++) exp_b_q.push_back({(w == BEATS - 1), r[64*w +: 64]});
  endtask

  // Running observation counters for instance a, written only by its monitor.
  int          a_vcnt  = 0;
  int          a_rises = 0;
  int          a_falls = 0;
  int          a_lasts = 0;
  logic        a_prev_valid = 1'b0;
  logic        a_prev_stall = 1'b0;
  logic [64:0] a_prev_beat  = '0;
  logic        b_prev_stall = 1'b0;
  logic [64:0] b_prev_beat  = '0;

  // Instance a monitor: beat order, stall stability, valid run shape.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (a_prev_stall) check("a_stall_stable", {a_m_tlast, a_m_tdata}, a_prev_beat);
      if (a_m_tvalid && a_m_tready) begin
        check("a_sb_has_exp", exp_a_q.size() != 0, 1);
        if (exp_a_q.size() != 0) check("a_beat", {a_m_tlast, a_m_tdata}, exp_a_q.pop_front());
        if (a_m_tlast) a_lasts <= a_lasts + 1;
      end
      if (a_m_tvalid) a_vcnt <= a_vcnt + 1;
      if (a_m_tvalid && !a_prev_valid) a_rises <= a_rises + 1;
      if (!a_m_tvalid && a_prev_valid) a_falls <= a_falls + 1;
      a_prev_valid <= a_m_tvalid;
      a_prev_stall <= a_m_tvalid && !a_m_tready;
      a_prev_beat  <= {a_m_tlast, a_m_tdata};
    end else begin
      a_prev_valid <= 1'b0;
      a_prev_stall <= 1'b0;
    end
  end

  // Instance b monitor: beat order and stall stability.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (b_prev_stall) check("b_stall_stable", {b_m_tlast, b_m_tdata}, b_prev_beat);
      if (b_m_tvalid && b_m_tready) begin
        check("b_sb_has_exp", exp_b_q.size() != 0, 1);
        if (exp_b_q.size() != 0) check("b_beat", {b_m_tlast, b_m_tdata}, exp_b_q.pop_front());
      end
      b_prev_stall <= b_m_tvalid && !b_m_tready;
      b_prev_beat  <= {b_m_tlast, b_m_tdata};
    end else begin
      b_prev_stall <= 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic write_a(input logic [IW-1:0] r);
    a_s_tdata  = r;
    a_s_tvalid = 1'b1;
    a_s_tlast  = 1'b1;
    tick();
    a_s_tvalid = 1'b0;
    a_s_tlast  = 1'b0;
  endtask

  task automatic wait_idle_a(input string tag, input int budget);
    int n;
    n = 0;
    while ((a_m_tvalid || a_fifo_level != 0) && n < budget) begin
      tick();
      n++;
    end
    check(tag, n < budget, 1);
    tick();
  endtask

  // ---------------- stimulus ----------------
  logic [IW-1:0] rec;
  int vc0, rs0, fl0, ls0, n, k;
  logic acc;

  initial begin
    a_s_tdata = '0; a_s_tvalid = 1'b0; a_s_tlast = 1'b0; a_m_tready = 1'b0;
    b_s_tdata = '0; b_s_tvalid = 1'b0; b_s_tlast = 1'b0; b_m_tready = 1'b0;
    aresetn = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_b_tready",  b_s_tready, 0);
    check("rst_a_tready",  a_s_tready, 1);
    check("rst_tvalid",    a_m_tvalid, 0);
    check("rst_tlast",     a_m_tlast, 0);
    check("rst_tdata",     a_m_tdata, 0);
    check("rst_rec",       a_rec_count, 0);
    check("rst_drop",      a_drop_count, 0);
    check("rst_level",     a_fifo_level, 0);
    check("rst_state",     a_dbg_state, ST_IDLE);
    check("tkeep_ones",    a_m_tkeep, 8'hFF);
    aresetn = 1'b1;
    tick();
    check("b_tready_after_rst", b_s_tready, 1);

    // One incrementing-byte record, ready high: first valid two edges after write
    a_m_tready = 1'b1;
    rec = inc_rec();
    push_exp_a(rec);
    write_a(rec);
    check("t1_level_after_wr", a_fifo_level, 1);
    check("t1_valid_n1", a_m_tvalid, 0);
    tick();
    check("t1_valid_n2", a_m_tvalid, 1);
    check("t1_beat0", a_m_tdata, 64'h0706050403020100);
    check("t1_beat0_tlast", a_m_tlast, 0);
    wait_idle_a("t1_timeout", 20);
    check("t1_rec_count", a_rec_count, 1);
    check("t1_sb_empty", exp_a_q.size(), 0);

    // Three records back-to-back: one unbroken run of 24 valid beats
    vc0 = a_vcnt; rs0 = a_rises; fl0 = a_falls;
    for (int r = 0; r < 3; r++) begin
      rec = make_rec(r + 1);
      push_exp_a(rec);
      write_a(rec);
    end
    wait_idle_a("t2_timeout", 40);
    check("t2_valid_beats", a_vcnt - vc0, 24);
    check("t2_one_rise", a_rises - rs0, 1);
    check("t2_one_fall", a_falls - fl0, 1);
    check("t2_rec_count", a_rec_count, 4);

    // Ready toggled 1010... across a record
    rec = make_rec(9);
    push_exp_a(rec);
    write_a(rec);
    n = 0;
    while ((a_m_tvalid || a_fifo_level != 0) && n < 60) begin
      a_m_tready = (n % 2 == 0);
      tick();
      n++;
    end
    check("t3_timeout", n < 60, 1);
    a_m_tready = 1'b1;
    tick();
    check("t3_rec_count", a_rec_count, 5);
    check("t3_sb_empty", exp_a_q.size(), 0);

    // Drop mode, ready low, 7 records: the first moves into the shift
    // register, the next 4 fill the buffer, the last 2 are dropped.
    a_m_tready = 1'b0;
    for (int r = 0; r < 7; r++) begin
      rec = make_rec(20 + r);
      if (r < 5) push_exp_a(rec);
      write_a(rec);
    end
    check("t4_level", a_fifo_level, 4);
    check("t4_drop", a_drop_count, 2);
    check("t4_tready_const", a_s_tready, 1);
    check("t4_held_beat0", a_m_tdata, 64'h1400_BEEF_504B_504B);
    a_m_tready = 1'b1;
    wait_idle_a("t4_timeout", 60);
    check("t4_rec_count", a_rec_count, 10);
    check("t4_sb_empty", exp_a_q.size(), 0);

    // Backpressure mode, ready low: exactly 5 records accepted, then tready drops
    k = 0;
    for (int i = 0; i < 10; i++) begin
      b_s_tdata  = make_rec(40 + k);
      b_s_tvalid = 1'b1;
      b_s_tlast  = 1'b1;
      acc = b_s_tready;
      if (acc) push_exp_b(b_s_tdata);
      tick();
      if (acc) k++;
    end
    b_s_tvalid = 1'b0;
    check("t5_accepted", k, 5);
    check("t5_tready_low", b_s_tready, 0);
    check("t5_level", b_fifo_level, 4);
    check("t5_drop_zero", b_drop_count, 0);
    b_m_tready = 1'b1;
    n = 0;
    while ((b_m_tvalid || b_fifo_level != 0) && n < 80) begin
      tick();
      n++;
    end
    check("t5_timeout", n < 80, 1);
    tick();
    check("t5_rec_count", b_rec_count, 5);
    check("t5_sb_empty", exp_b_q.size(), 0);

    // Reset pulsed while beat 3 is on the wire
    a_m_tready = 1'b1;
    ls0 = a_lasts;
    rec = make_rec(60);
    push_exp_a(rec);
    write_a(rec);
    repeat (4) tick();
    check("t6_beat3_on_wire", a_m_tdata, 64'h3C03_BEEF_BEEF_3C03);
    aresetn = 1'b0;
    tick();
    exp_a_q.delete();
    check("t6_valid_low", a_m_tvalid, 0);
    check("t6_tlast_low", a_m_tlast, 0);
    check("t6_tdata_zero", a_m_tdata, 0);
    check("t6_rec_zero", a_rec_count, 0);
    check("t6_drop_zero", a_drop_count, 0);
    check("t6_level_zero", a_fifo_level, 0);
    check("t6_state_idle", a_dbg_state, ST_IDLE);
    aresetn = 1'b1;
    tick();
    check("t6_no_tlast", a_lasts - ls0, 0);
    rec = make_rec(61);
    push_exp_a(rec);
    write_a(rec);
    tick();
    check("t6_restart_beat0", a_m_tdata, 64'h3D00_BEEF_504B_504B);
    wait_idle_a("t6_timeout", 20);
    check("t6_rec_count", a_rec_count, 1);
    check("t6_sb_empty", exp_a_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
